// File: rtl/matrix_traverse_pkg.sv
// Shared types for matrix_traverse: traversal modes, top-level state and spiral direction.
package matrix_traverse_pkg;

  typedef enum logic [1:0] {
    ROW_MAJ    = 2'd0,
    COL_MAJ    = 2'd1,
    SPIRAL_CW  = 2'd2,
    SPIRAL_CCW = 2'd3
  } mode_t;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    L2R = 2'd0,
    T2B = 2'd1,
    R2L = 2'd2,
    B2T = 2'd3
  } dir_t;

  // Clockwise spirals open along the top row, counter-clockwise ones down the left column.
  function automatic dir_t first_dir(input mode_t m);
    return (m == SPIRAL_CCW) ? T2B : L2R;
  endfunction

endpackage

// File: rtl/matrix_traverse_if.sv
// Stream/control bundle for matrix_traverse; data_out_last exists only with MATRIX_TRAVERSE_LAST_EN.
interface matrix_traverse_if #(
  parameter int DATA_WIDTH = 8,
  parameter int R_WIDTH    = 3,
  parameter int C_WIDTH    = 3
);
  logic [R_WIDTH-1:0]    row;
  logic [C_WIDTH-1:0]    col;
  logic [1:0]            mode;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  data_in_rdy;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_rdy;
  logic                  dim_err;
`ifdef MATRIX_TRAVERSE_LAST_EN
  logic                  data_out_last;
`endif

  modport master (
    output row, col, mode, data_in, data_in_valid, data_out_rdy,
`ifdef MATRIX_TRAVERSE_LAST_EN
    input  data_out_last,
`endif
    input  data_in_rdy, data_out, data_out_valid, dim_err
  );

  modport slave (
    input  row, col, mode, data_in, data_in_valid, data_out_rdy,
`ifdef MATRIX_TRAVERSE_LAST_EN
    output data_out_last,
`endif
    output data_in_rdy, data_out, data_out_valid, dim_err
  );
endinterface

// File: rtl/matrix_addr_gen.sv
// Read-position generator for matrix_traverse. rd_r/rd_c is the position whose element is
// loaded into the output register this cycle (origin on start, successor on advance).
module matrix_addr_gen import matrix_traverse_pkg::*; #(
  parameter int R_WIDTH = 3,
  parameter int C_WIDTH = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               advance,
  input  mode_t              mode,
  input  logic [R_WIDTH-1:0] row,
  input  logic [C_WIDTH-1:0] col,
  output logic [R_WIDTH-1:0] rd_r,
  output logic [C_WIDTH-1:0] rd_c
);

  logic [R_WIDTH-1:0] r_q, r_d, r_s, top_q, top_d, top_s, bot_q, bot_d, bot_s;
  logic [C_WIDTH-1:0] c_q, c_d, c_s, left_q, left_d, left_s, right_q, right_d, right_s;
  dir_t               dir_q, dir_d, dir_s;

  // Successor of the current position; spiral turns shrink the bound just walked.
  always_comb begin
    r_s = r_q; c_s = c_q; top_s = top_q; bot_s = bot_q;
    left_s = left_q; right_s = right_q; dir_s = dir_q;
    case (mode)
      ROW_MAJ: begin
        if (c_q == col - C_WIDTH'(1)) begin c_s = C_WIDTH'(0); r_s = r_q + R_WIDTH'(1); end
        else begin c_s = c_q + C_WIDTH'(1); end
      end
      COL_MAJ: begin
        if (r_q == row - R_WIDTH'(1)) begin r_s = R_WIDTH'(0); c_s = c_q + C_WIDTH'(1); end
        else begin r_s = r_q + R_WIDTH'(1); end
      end
      SPIRAL_CW: begin
        case (dir_q)
          L2R: if (c_q == right_q) begin dir_s = T2B; top_s = top_q + R_WIDTH'(1); r_s = r_q + R_WIDTH'(1); end
               else begin c_s = c_q + C_WIDTH'(1); end
          T2B: if (r_q == bot_q) begin dir_s = R2L; right_s = right_q - C_WIDTH'(1); c_s = c_q - C_WIDTH'(1); end
               else begin r_s = r_q + R_WIDTH'(1); end
          R2L: if (c_q == left_q) begin dir_s = B2T; bot_s = bot_q - R_WIDTH'(1); r_s = r_q - R_WIDTH'(1); end
               else begin c_s = c_q - C_WIDTH'(1); end
          B2T: if (r_q == top_q) begin dir_s = L2R; left_s = left_q + C_WIDTH'(1); c_s = c_q + C_WIDTH'(1); end
               else begin r_s = r_q - R_WIDTH'(1); end
          default: dir_s = L2R;
        endcase
      end
      SPIRAL_CCW: begin
        case (dir_q)
          T2B: if (r_q == bot_q) begin dir_s = L2R; left_s = left_q + C_WIDTH'(1); c_s = c_q + C_WIDTH'(1); end
               else begin r_s = r_q + R_WIDTH'(1); end
          L2R: if (c_q == right_q) begin dir_s = B2T; bot_s = bot_q - R_WIDTH'(1); r_s = r_q - R_WIDTH'(1); end
               else begin c_s = c_q + C_WIDTH'(1); end
          B2T: if (r_q == top_q) begin dir_s = R2L; right_s = right_q - C_WIDTH'(1); c_s = c_q - C_WIDTH'(1); end
               else begin r_s = r_q - R_WIDTH'(1); end
          R2L: if (c_q == left_q) begin dir_s = T2B; top_s = top_q + R_WIDTH'(1); r_s = r_q + R_WIDTH'(1); end
               else begin c_s = c_q - C_WIDTH'(1); end
          default: dir_s = T2B;
        endcase
      end
      default: dir_s = dir_q;
    endcase
  end

  // Select origin, successor or hold.
  always_comb begin
    if (start) begin
      r_d = R_WIDTH'(0); c_d = C_WIDTH'(0); top_d = R_WIDTH'(0); bot_d = row - R_WIDTH'(1);
      left_d = C_WIDTH'(0); right_d = col - C_WIDTH'(1); dir_d = first_dir(mode);
    end else if (advance) begin
      r_d = r_s; c_d = c_s; top_d = top_s; bot_d = bot_s;
      left_d = left_s; right_d = right_s; dir_d = dir_s;
    end else begin
      r_d = r_q; c_d = c_q; top_d = top_q; bot_d = bot_q;
      left_d = left_q; right_d = right_q; dir_d = dir_q;
    end
  end

  assign rd_r = r_d;
  assign rd_c = c_d;

  // Position, bound and direction registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_q <= R_WIDTH'(0); c_q <= C_WIDTH'(0); top_q <= R_WIDTH'(0); bot_q <= R_WIDTH'(0);
      left_q <= C_WIDTH'(0); right_q <= C_WIDTH'(0); dir_q <= L2R;
    end else begin
      r_q <= r_d; c_q <= c_d; top_q <= top_d; bot_q <= bot_d;
      left_q <= left_d; right_q <= right_d; dir_q <= dir_d;
    end
  end

endmodule

// File: rtl/matrix_traverse.sv
// Buffers one row-major R x C matrix, then replays it in row/column-major or CW/CCW spiral order.
// Optional data_out_last output is enabled by defining MATRIX_TRAVERSE_LAST_EN.
module matrix_traverse import matrix_traverse_pkg::*; #(
  parameter int DATA_WIDTH = 8,
  parameter int R_WIDTH    = 3,
  parameter int C_WIDTH    = 3
) (
  input logic              clk,
  input logic              rstn,
  matrix_traverse_if.slave bus
);

  localparam int CNT_W = R_WIDTH + C_WIDTH;
  localparam int DEPTH = 1 << CNT_W;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_t                state_q, state_d;
  logic                  first_q, first_d;
  logic [R_WIDTH-1:0]    row_q, row_d, wr_r_q, wr_r_d;
  logic [C_WIDTH-1:0]    col_q, col_d, wr_c_q, wr_c_d;
  mode_t                 mode_q, mode_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  in_rdy_q, in_rdy_d, out_valid_q, out_valid_d, dim_err_q, dim_err_d;

  logic                  in_hs_s, out_hs_s, dim_bad_s, wr_en_s, last_wr_s;
  logic [R_WIDTH-1:0]    row_e_s, rd_r_s;
  logic [C_WIDTH-1:0]    col_e_s, rd_c_s;
  mode_t                 mode_e_s;
  logic [CNT_W-1:0]      prod_s;
  logic [DATA_WIDTH-1:0] rd_data_s;

  // The first beat's dimensions apply in the same cycle they are latched (matters for 1x1).
  always_comb begin
    if (first_q && state_q == LOAD) begin
      row_e_s = bus.row; col_e_s = bus.col; mode_e_s = mode_t'(bus.mode);
    end else begin
      row_e_s = row_q; col_e_s = col_q; mode_e_s = mode_q;
    end
    in_hs_s   = in_rdy_q && bus.data_in_valid;
    out_hs_s  = out_valid_q && bus.data_out_rdy;
    dim_bad_s = in_hs_s && first_q && (bus.row == R_WIDTH'(0) || bus.col == C_WIDTH'(0));
    wr_en_s   = in_hs_s && !dim_bad_s;
    last_wr_s = wr_en_s && (wr_r_q == row_e_s - R_WIDTH'(1)) && (wr_c_q == col_e_s - C_WIDTH'(1));
    prod_s    = CNT_W'(row_e_s) * CNT_W'(col_e_s);
  end

  matrix_addr_gen #(.R_WIDTH(R_WIDTH), .C_WIDTH(C_WIDTH)) u_addr_gen (
    .clk     (clk),
    .rstn    (rstn),
    .start   (last_wr_s),
    .advance (out_hs_s),
    .mode    (mode_e_s),
    .row     (row_e_s),
    .col     (col_e_s),
    .rd_r    (rd_r_s),
    .rd_c    (rd_c_s)
  );

  // Bypass the element being written so a 1x1 matrix is available without a bubble.
  always_comb begin
    if (wr_en_s && wr_r_q == rd_r_s && wr_c_q == rd_c_s) begin
      rd_data_s = bus.data_in;
    end else begin
      rd_data_s = mem_q[{rd_r_s, rd_c_s}];
    end
  end

  // Next-state for load/drain sequencing, write pointer, counter and output register.
  always_comb begin
    state_d = state_q; first_d = first_q; wr_r_d = wr_r_q; wr_c_d = wr_c_q;
    cnt_d = cnt_q; data_out_d = data_out_q;
    if (in_hs_s && first_q) begin
      row_d = bus.row; col_d = bus.col; mode_d = mode_t'(bus.mode);
    end else begin
      row_d = row_q; col_d = col_q; mode_d = mode_q;
    end
    case (state_q)
      LOAD: begin
        if (wr_en_s) begin
          first_d = 1'b0;
          if (last_wr_s) begin
            state_d = DRAIN; first_d = 1'b1; wr_r_d = R_WIDTH'(0); wr_c_d = C_WIDTH'(0);
            cnt_d = prod_s; data_out_d = rd_data_s;
          end else if (wr_c_q == col_e_s - C_WIDTH'(1)) begin
            wr_c_d = C_WIDTH'(0); wr_r_d = wr_r_q + R_WIDTH'(1);
          end else begin
            wr_c_d = wr_c_q + C_WIDTH'(1);
          end
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (out_hs_s) begin
          cnt_d = cnt_q - CNT_W'(1); data_out_d = rd_data_s;
          if (cnt_q == CNT_W'(1)) begin
            state_d = LOAD;
          end else begin
            state_d = DRAIN;
          end
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = LOAD;
    endcase
    in_rdy_d    = (state_d == LOAD);
    out_valid_d = (state_d == DRAIN);
    dim_err_d   = dim_bad_s;
  end

  // Buffer write; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[{wr_r_q, wr_c_q}] <= bus.data_in;
    end
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= LOAD; first_q <= 1'b1; row_q <= R_WIDTH'(0); col_q <= C_WIDTH'(0);
      mode_q <= ROW_MAJ; wr_r_q <= R_WIDTH'(0); wr_c_q <= C_WIDTH'(0); cnt_q <= CNT_W'(0);
      data_out_q <= DATA_WIDTH'(0); in_rdy_q <= 1'b0; out_valid_q <= 1'b0; dim_err_q <= 1'b0;
    end else begin
      state_q <= state_d; first_q <= first_d; row_q <= row_d; col_q <= col_d;
      mode_q <= mode_d; wr_r_q <= wr_r_d; wr_c_q <= wr_c_d; cnt_q <= cnt_d;
      data_out_q <= data_out_d; in_rdy_q <= in_rdy_d; out_valid_q <= out_valid_d; dim_err_q <= dim_err_d;
    end
  end

  assign bus.data_in_rdy    = in_rdy_q;
  assign bus.data_out       = data_out_q;
  assign bus.data_out_valid = out_valid_q;
  assign bus.dim_err        = dim_err_q;

`ifdef MATRIX_TRAVERSE_LAST_EN
  logic last_q;

  // Last flag follows the counter value that will be presented next cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_q <= 1'b0;
    end else begin
      last_q <= (state_d == DRAIN) && (cnt_d == CNT_W'(1));
    end
  end

  assign bus.data_out_last = last_q;
`endif

endmodule

// File: doc/matrix_traverse.md
# matrix_traverse

Parametrised successor to the spiral output block. Buffers one R×C matrix received row-major on a valid/ready stream, then replays it on a second valid/ready stream in one of four run-time-selectable orders: row-major, column-major, clockwise spiral, counter-clockwise spiral. It sits between a row-major producer and any consumer needing reordered elements, one matrix in flight at a time.

## Interface

- DATA_WIDTH, 8: element width.
- R_WIDTH, 3: row-dimension width; buffer holds 2^R_WIDTH rows.
- C_WIDTH, 3: column-dimension width; buffer holds 2^C_WIDTH columns.

- clk  in  1  single clock, rising edge.
- rstn  in  1  asynchronous, active-low reset.
- row  in  R_WIDTH  row count; legal range 1..2^R_WIDTH-1; sampled on first input beat.
- col  in  C_WIDTH  column count; legal range 1..2^C_WIDTH-1; sampled on first input beat.
- mode  in  2  traversal order: 0 row-major, 1 column-major, 2 spiral CW, 3 spiral CCW; sampled on first input beat.
- data_in  in  DATA_WIDTH  input element.
- data_in_valid  in  1  input beat valid.
- data_in_rdy  out  1  block accepts an input beat.
- data_out  out  DATA_WIDTH  output element.
- data_out_valid  out  1  output beat valid.
- data_out_rdy  in  1  consumer accepts an output beat.
- dim_err  out  1  one-cycle pulse: first beat carried row==0 or col==0.
- data_out_last  out  1  final element of the matrix; present only with MATRIX_TRAVERSE_LAST_EN.

## Operation

- States: LOAD, DRAIN.
- Beat transfers on valid&&rdy, on either side.
- LOAD
  - data_in_rdy=1.
  - First beat latches row, col, mode.
  - If row==0 or col==0: beat is discarded, dim_err pulses, block stays in LOAD with the first-beat flag still set.
  - Otherwise elements are written row-major at (wr_r, wr_c).
  - On the beat at (row-1, col-1) the block goes to DRAIN.
- DRAIN
  - data_in_rdy=0. data_out_valid=1.
  - Remaining-count counter is R_WIDTH+C_WIDTH bits, loaded with row*col.
  - Each output handshake decrements the counter and advances the read position.
  - The handshake that brings the counter to 0 returns the block to LOAD.
- Row-major: c increments and wraps to 0 with r+1. Column-major: r increments and wraps with c+1.
- Spiral bounds are top/bottom/left/right, initialised to 0/row-1/0/col-1. Direction states are L2R, T2B, R2L, B2T.
- CW spiral: starts L2R at (0,0).
  - L2R end at c==right: go T2B, top++, r++.
  - T2B end at r==bottom: go R2L, right--, c--.
  - R2L end at c==left: go B2T, bottom--, r--.
  - B2T end at r==top: go L2R, left++, c++.
- CCW spiral: starts T2B at (0,0), order T2B→L2R→B2T→R2L.
  - T2B end at r==bottom: left++.
  - L2R end at c==right: bottom--.
  - B2T end at r==top: right--.
  - R2L end at c==left: top++.
- Degenerate shapes (1×N, N×1, 1×1) terminate on the counter alone. Positions computed after the final turn are never emitted.
- Address arithmetic is modulo field width. Bounds never underflow while the counter is non-zero.

## Timing

- Reset values: data_in_rdy=0, data_out_valid=0, data_out=0, dim_err=0, data_out_last=0. State is LOAD, all counters and bounds are 0.
- data_in_rdy rises on the first clock edge after rstn deasserts.
- Throughput is 1 beat/cycle in each phase.
- The last input handshake at edge N gives data_out_valid=1 with the first element after edge N, i.e. zero bubble cycles.
- data_in_rdy=0 over that same interval.
- Final output handshake at edge M gives data_out_valid=0 and data_in_rdy=1 after edge M.
- data_out and data_out_last hold stable while data_out_valid && !data_out_rdy.
- row, col and mode are ignored after the first beat until the matrix completes.
- rstn asserted mid-LOAD or mid-DRAIN aborts the matrix. Outputs return to reset values immediately. Buffer contents are don't-care.

## Configuration

- MATRIX_TRAVERSE_LAST_EN defined: data_out_last port exists. It is 1 with data_out_valid when the counter==1, else 0.
- Undefined: port and its logic are absent. All other behaviour is identical.

## Structure

- matrix_traverse_pkg holds:
  - mode_t enum (ROW_MAJ, COL_MAJ, SPIRAL_CW, SPIRAL_CCW).
  - top-level state enum (LOAD, DRAIN).
  - direction enum (L2R, T2B, R2L, B2T).
- Sub-module matrix_addr_gen holds the read-position, bound and direction logic.
  - Inputs: start, advance, mode, row, col.
  - Outputs: rd_r, rd_c.
- Top level holds the buffer, write side, counter and handshakes.

## Test plan

- 3×4, mode 2, inputs 0..11 row-major: outputs 0,1,2,3,7,11,10,9,8,4,5,6, then data_in_rdy=1 next cycle.
- 3×4, mode 3, inputs 0..11: outputs 0,4,8,9,10,11,7,3,2,1,5,6. Mode 1: 0,4,8,1,5,9,2,6,10,3,7,11.
- 1×1, 1×5, 5×1 in all modes with inputs 0..: output equals input order; exactly row*col beats; last asserted on final beat only (LAST_EN).
- 4×4 CW with data_out_rdy toggling every other cycle: sequence 0,1,2,3,7,11,15,14,13,12,8,4,5,6,10,9; data_out stable during stalls; no dropped or repeated beats.
- First beat with row=0, col=3: dim_err pulses one cycle; a following valid 2×2 matrix 0..3 in mode 2 outputs 0,1,3,2.
- rstn pulsed after 5 of 12 outputs: outputs go to reset values; a new 2×3 mode 0 matrix 0..5 outputs 0..5.
